// File: rtl/fusion_blend_v2_pkg.sv
// Shared types and helpers for the fusion_blend_v2 temporal blend stage.
package fusion_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC    = 2'd0,
    MODE_ROUND    = 2'd1,
    MODE_PASS_NEW = 2'd2,
    MODE_PASS_OLD = 2'd3
  } mode_e;

  function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

  // A one-beat frame still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fusion_blend_v2_if.sv
// Input/output stream bundle for fusion_blend_v2.
interface fusion_blend_v2_if #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIX_W           = 8,
  parameter int WGT_W           = 8
);
  logic [1:0]                       mode;
  logic                             in_valid;
  logic                             in_ready;
  logic [PIX_W*PIXELS_PER_BEAT-1:0] old_frame;
  logic [PIX_W*PIXELS_PER_BEAT-1:0] new_frame;
  logic [WGT_W*PIXELS_PER_BEAT-1:0] weight;
  logic                             out_valid;
  logic                             out_ready;
  logic [PIX_W*PIXELS_PER_BEAT-1:0] fused_frame;
  logic                             out_last;
  logic                             frame_done;

  // Upstream / downstream side driving the blender.
  modport master (
    output mode, in_valid, old_frame, new_frame, weight, out_ready,
    input  in_ready, out_valid, fused_frame, out_last, frame_done
  );

  // The blender itself.
  modport slave (
    input  mode, in_valid, old_frame, new_frame, weight, out_ready,
    output in_ready, out_valid, fused_frame, out_last, frame_done
  );
endinterface

// File: rtl/fusion_blend_v2_lane.sv
// Single-pixel blend datapath: S1 input regs, S2 products, S3 add/round/shift/saturate.
module fusion_lane
  import fusion_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_e            mode_s2,
  input  logic [PIX_W-1:0] x_in,
  input  logic [PIX_W-1:0] y_in,
  input  logic [WGT_W-1:0] d_in,
  output logic [PIX_W-1:0] fused
);
  localparam int PROD_W = PIX_W + WGT_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  logic [PIX_W-1:0]  x1_q, x1_d, y1_q, y1_d;
  logic [WGT_W-1:0]  d1_q, d1_d;
  logic [PROD_W-1:0] px2_q, px2_d, py2_q, py2_d;
  logic [PIX_W-1:0]  x2_q, x2_d, y2_q, y2_d;
  logic [PIX_W-1:0]  res3_q, res3_d;

  logic [WGT_W-1:0]  dbar;
  logic [SUM_W-1:0]  rnd, sum, shifted;
  logic [PIX_W-1:0]  blend, res;

  // Next-state for all three stages; everything holds when en is low.
  always_comb begin
    dbar    = ~d1_q;
    rnd     = (mode_s2 == MODE_ROUND) ? (SUM_W'(1) << (WGT_W - 1)) : '0;
    sum     = SUM_W'(px2_q) + SUM_W'(py2_q) + rnd;
    shifted = sum >> WGT_W;
    blend   = (shifted > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : shifted[PIX_W-1:0];
    case (mode_s2)
      MODE_PASS_NEW: res = y2_q;
      MODE_PASS_OLD: res = x2_q;
      default:       res = blend;
    endcase

    x1_d   = x1_q;
    y1_d   = y1_q;
    d1_d   = d1_q;
    px2_d  = px2_q;
    py2_d  = py2_q;
    x2_d   = x2_q;
    y2_d   = y2_q;
    res3_d = res3_q;
    if (en) begin
      x1_d   = x_in;
      y1_d   = y_in;
      d1_d   = d_in;
      px2_d  = PROD_W'(x1_q) * PROD_W'(dbar);
      py2_d  = PROD_W'(y1_q) * PROD_W'(d1_q);
      x2_d   = x1_q;
      y2_d   = y1_q;
      res3_d = res;
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q   <= '0;
      y1_q   <= '0;
      d1_q   <= '0;
      px2_q  <= '0;
      py2_q  <= '0;
      x2_q   <= '0;
      y2_q   <= '0;
      res3_q <= '0;
    end else begin
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      d1_q   <= d1_d;
      px2_q  <= px2_d;
      py2_q  <= py2_d;
      x2_q   <= x2_d;
      y2_q   <= y2_d;
      res3_q <= res3_d;
    end
  end

  assign fused = res3_q;

endmodule

// File: rtl/fusion_blend_v2.sv
// Temporal fusion blender top: valid/ready chain, per-frame mode latch, beat counters, framing.
module fusion_blend_v2
  import fusion_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIX_W           = 8,
  parameter int WGT_W           = 8,
  parameter int IMAGE_DIM       = 512
) (
  input logic             clk,
  input logic             rst,
  fusion_blend_v2_if.slave bus
);
  localparam int BPF   = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int CNT_W = cnt_width(BPF);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPF - 1);

  logic             en, acc, out_hs, first_beat;
  mode_e            mode_in, mode_eff;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  mode_e            mode1_q, mode1_d, mode2_q, mode2_d, mode_lat_q, mode_lat_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic             done_q, done_d;

  logic [PIX_W*PIXELS_PER_BEAT-1:0] fused_w;

  assign en     = !v3_q || bus.out_ready;
  assign acc    = bus.in_valid && en;
  assign out_hs = v3_q && bus.out_ready;

  // Valid chain, mode pipeline, mode latch and both beat counters.
  always_comb begin
    mode_in    = mode_e'(bus.mode);
    first_beat = (in_cnt_q == '0);
    // Beat 0 uses the live mode so the frame's first beat does not wait on the latch.
    mode_eff   = first_beat ? mode_in : mode_lat_q;

    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    mode1_d    = mode1_q;
    mode2_d    = mode2_q;
    mode_lat_d = mode_lat_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    done_d     = out_hs && (out_cnt_q == LAST_IDX);

    if (en) begin
      v1_d    = bus.in_valid;
      v2_d    = v1_q;
      v3_d    = v2_q;
      mode1_d = mode_eff;
      mode2_d = mode1_q;
    end
    if (acc) begin
      in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + CNT_W'(1);
      if (first_beat) mode_lat_d = mode_in;
    end
    if (out_hs) begin
      out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + CNT_W'(1);
    end
  end

  // Control registers; reset discards in-flight beats and restarts framing.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      mode1_q    <= MODE_TRUNC;
      mode2_q    <= MODE_TRUNC;
      mode_lat_q <= MODE_TRUNC;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      mode1_q    <= mode1_d;
      mode2_q    <= mode2_d;
      mode_lat_q <= mode_lat_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
    end
  end

  for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_lane
    fusion_lane #(
      .PIX_W (PIX_W),
      .WGT_W (WGT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode_s2 (mode2_q),
      .x_in    (bus.old_frame[i*PIX_W +: PIX_W]),
      .y_in    (bus.new_frame[i*PIX_W +: PIX_W]),
      .d_in    (bus.weight[i*WGT_W +: WGT_W]),
      .fused   (fused_w[i*PIX_W +: PIX_W])
    );
  end

  assign bus.in_ready    = en;
  assign bus.out_valid   = v3_q;
  assign bus.out_last    = v3_q && (out_cnt_q == LAST_IDX);
  assign bus.frame_done  = done_q;
  assign bus.fused_frame = fused_w;

endmodule

// File: tb/tb_fusion_blend_v2.sv
// Self-checking bench for fusion_blend_v2 (4 beats per frame) against a per-pixel arithmetic model.
module tb_fusion_blend_v2;
  localparam int PPB = 16;
  localparam int PW  = 8;
  localparam int WW  = 8;
  localparam int DIM = 8;
  localparam int BPF = DIM * DIM / PPB;
  localparam int VW  = PW * PPB;
  localparam int DW  = WW * PPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fusion_blend_v2_if #(.PIXELS_PER_BEAT(PPB), .PIX_W(PW), .WGT_W(WW)) bus ();

  fusion_blend_v2 #(
    .PIXELS_PER_BEAT (PPB),
    .PIX_W           (PW),
    .WGT_W           (WW),
    .IMAGE_DIM       (DIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: frame position, frame mode, expected beats in order.
  int            m_cnt  = 0;
  int            m_mode = 0;
  logic [VW-1:0] exp_q[$];
  bit            last_q[$];
  bit            pend_done = 1'b0;

  function automatic logic [VW-1:0] ref_beat(input int m, input logic [VW-1:0] x,
                                             input logic [VW-1:0] y, input logic [DW-1:0] d);
    logic [VW-1:0] r;
    int xi, yi, di, s;
    r = '0;
    for (int i = 0; i < PPB; i++) begin
      xi = int'(x[i*PW +: PW]);
      yi = int'(y[i*PW +: PW]);
      di = int'(d[i*WW +: WW]);
      if (m == 2) s = yi;
      else if (m == 3) s = xi;
      else begin
        s = xi * ((1 << WW) - 1 - di) + yi * di + ((m == 1) ? (1 << (WW - 1)) : 0);
        s = s / (1 << WW);
        if (s > (1 << PW) - 1) s = (1 << PW) - 1;
      end
      r[i*PW +: PW] = s[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] splat_p(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < PPB; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] splat_w(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < PPB; i++) r[i*WW +: WW] = WW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_model();
    m_cnt = 0;
    m_mode = 0;
    exp_q.delete();
    last_q.delete();
    pend_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // One clock: drive inputs, sample just before the edge, advance the model.
  task automatic cycle(input bit iv, input logic [1:0] md, input logic [VW-1:0] x,
                       input logic [VW-1:0] y, input logic [DW-1:0] d, input bit ordy,
                       output bit got, output logic [VW-1:0] ef, output logic [VW-1:0] af,
                       output logic el, output bit al, output bit fd, output bit efd,
                       output bit acc);
    int m;
    bus.in_valid  = iv;
    bus.mode      = md;
    bus.old_frame = x;
    bus.new_frame = y;
    bus.weight    = d;
    bus.out_ready = ordy;
    #1;
    got = bus.out_valid && bus.out_ready;
    af  = bus.fused_frame;
    al  = bus.out_last;
    ef  = 'x;
    el  = 1'bx;
    if (got && exp_q.size() > 0) begin
      ef = exp_q.pop_front();
      el = last_q.pop_front();
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      if (m_cnt == 0) m_mode = int'(md);
      m = m_mode;
      exp_q.push_back(ref_beat(m, x, y, d));
      last_q.push_back(m_cnt == BPF - 1);
      m_cnt = (m_cnt + 1) % BPF;
    end
    fd  = bus.frame_done;
    efd = pend_done;
    pend_done = got && (el === 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.fused_frame !== '0) begin errors++; $display("FAIL reset_fused: got %h want 0", bus.fused_frame); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
  endtask

  // Fixed-pattern frame; k0/k1 are the lane-0 values required for the first two outputs.
  task automatic run_fixed(input string nm, input logic [1:0] md, input int x0, input int y0,
                           input int d0, input int x1, input int y1, input int d1,
                           input int k0, input int k1);
    bit got, al, fd, efd, acc;
    logic el;
    logic [VW-1:0] ef, af;
    int acc_t, nout;
    acc_t = -1;
    nout  = 0;
    for (int t = 0; t < 20; t++) begin
      if (t % 2 == 0) cycle(t < BPF, md, splat_p(x0), splat_p(y0), splat_w(d0), 1'b1, got, ef, af, el, al, fd, efd, acc);
      else            cycle(t < BPF, md, splat_p(x1), splat_p(y1), splat_w(d1), 1'b1, got, ef, af, el, al, fd, efd, acc);
      if (acc && acc_t < 0) acc_t = t;
      if (got) begin
        checks++;
        if (af !== ef || al !== el) begin errors++; $display("FAIL %s_beat%0d: got %h last %b want %h last %b", nm, nout, af, al, ef, el); end
        if (nout == 0) begin
          checks++; if (int'(af[PW-1:0]) != k0) begin errors++; $display("FAIL %s_value0: got %0d want %0d", nm, af[PW-1:0], k0); end
          checks++; if (t - acc_t != 3) begin errors++; $display("FAIL %s_latency: got %0d want 3", nm, t - acc_t); end
        end
        if (nout == 1) begin
          checks++; if (int'(af[PW-1:0]) != k1) begin errors++; $display("FAIL %s_value1: got %0d want %0d", nm, af[PW-1:0], k1); end
        end
        nout++;
      end
    end
    checks++; if (nout != BPF) begin errors++; $display("FAIL %s_count: got %0d want %0d", nm, nout, BPF); end
  endtask

  task automatic test_truncate();
    run_fixed("trunc", 2'd0, 200, 100, 128, 200, 100, 128, 149, 149);
  endtask

  task automatic test_round();
    run_fixed("round", 2'd1, 255, 255, 0, 255, 255, 0, 254, 254);
  endtask

  task automatic test_extreme();
    run_fixed("extreme", 2'd0, 9, 77, 255, 9, 77, 0, 76, 8);
  endtask

  task automatic test_backpressure();
    bit got, al, fd, efd, acc;
    logic el;
    logic [VW-1:0] ef, af, held, y;
    int b, nout;
    b = 0;
    nout = 0;
    held = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < PPB; i++) y[i*PW +: PW] = PW'(b * PPB + i);
      if (t == 4) held = bus.fused_frame;
      if (t >= 5 && t <= 9) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.fused_frame !== held) begin
          errors++; $display("FAIL bp_hold_t%0d: got valid %b data %h want valid 1 data %h", t, bus.out_valid, bus.fused_frame, held);
        end
      end
      cycle(b < 10, 2'd2, rnd_vec(), y, rnd_vec(), !(t >= 4 && t < 9), got, ef, af, el, al, fd, efd, acc);
      if (acc) b++;
      if (t >= 4 && t < 9) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_t%0d: got %b want 0", t, bus.in_ready); end
      end
      if (got) begin
        checks++;
        if (af !== ef || al !== el) begin errors++; $display("FAIL bp_beat%0d: got %h last %b want %h last %b", nout, af, al, ef, el); end
        nout++;
      end
    end
    checks++; if (nout != 10) begin errors++; $display("FAIL bp_count: got %0d want 10", nout); end
  endtask

  task automatic test_framing();
    bit got, al, fd, efd, acc;
    logic el;
    logic [VW-1:0] ef, af;
    logic [VW-1:0] xs[8], ys[8];
    int nout, ndone;
    do_reset();
    for (int i = 0; i < 8; i++) begin xs[i] = rnd_vec(); ys[i] = rnd_vec(); end
    nout = 0;
    ndone = 0;
    for (int t = 0; t < 20; t++) begin
      if (t < 8) cycle(1'b1, (t < 2) ? 2'd2 : 2'd3, xs[t], ys[t], rnd_vec(), 1'b1, got, ef, af, el, al, fd, efd, acc);
      else       cycle(1'b0, 2'd0, '0, '0, '0, 1'b1, got, ef, af, el, al, fd, efd, acc);
      checks++; if (fd !== efd) begin errors++; $display("FAIL frm_done_t%0d: got %b want %b", t, fd, efd); end
      if (fd) ndone++;
      if (got) begin
        checks++;
        if (af !== ef || al !== el) begin errors++; $display("FAIL frm_beat%0d: got %h last %b want %h last %b", nout, af, al, ef, el); end
        checks++;
        if (af !== ((nout < 4) ? ys[nout] : xs[nout])) begin
          errors++; $display("FAIL frm_pass%0d: got %h want %h", nout, af, (nout < 4) ? ys[nout] : xs[nout]);
        end
        nout++;
      end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL frm_done_count: got %0d want 2", ndone); end
  endtask

  task automatic test_random();
    bit got, al, fd, efd, acc;
    logic el;
    logic [VW-1:0] ef, af;
    int b, nout;
    b = 0;
    nout = 0;
    for (int t = 0; t < 200; t++) begin
      cycle((b < 12) && ($urandom_range(9) < 7), 2'($urandom_range(3)), rnd_vec(), rnd_vec(), rnd_vec(),
            $urandom_range(9) < 7, got, ef, af, el, al, fd, efd, acc);
      if (acc) b++;
      checks++; if (fd !== efd) begin errors++; $display("FAIL rnd_done_t%0d: got %b want %b", t, fd, efd); end
      if (got) begin
        checks++;
        if (af !== ef || al !== el) begin errors++; $display("FAIL rnd_beat%0d: got %h last %b want %h last %b", nout, af, al, ef, el); end
        nout++;
      end
    end
    checks++; if (nout != 12) begin errors++; $display("FAIL rnd_count: got %0d want 12", nout); end
  endtask

  task automatic test_reset_mid();
    bit got, al, fd, efd, acc;
    logic el;
    logic [VW-1:0] ef, af;
    int nout, last_at;
    do_reset();
    for (int t = 0; t < 3; t++) cycle(t < 2, 2'd1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, got, ef, af, el, al, fd, efd, acc);
    do_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    nout = 0;
    last_at = -1;
    for (int t = 0; t < 20; t++) begin
      cycle(t < BPF, 2'd0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, got, ef, af, el, al, fd, efd, acc);
      if (got) begin
        checks++;
        if (af !== ef || al !== el) begin errors++; $display("FAIL rmid_beat%0d: got %h last %b want %h last %b", nout, af, al, ef, el); end
        if (al) last_at = nout;
        nout++;
      end
    end
    checks++; if (last_at != BPF - 1 || nout != BPF) begin errors++; $display("FAIL rmid_last_pos: got last at %0d of %0d want %0d of %0d", last_at, nout, BPF - 1, BPF); end
  endtask

  initial begin
    bus.mode      = 2'd0;
    bus.in_valid  = 1'b0;
    bus.old_frame = '0;
    bus.new_frame = '0;
    bus.weight    = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_truncate();
    test_round();
    test_extreme();
    test_backpressure();
    test_framing();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
